// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and constants for the shift instruction sequencer
//
// Purpose: sequencer state encoding, supported shift/rotate opcodes, ALU
// function codes and the bit positions of the IR fields, plus two small
// opcode helpers used by the decode logic.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6
    } state_e;

    // Supported instruction opcodes (IR[31:27])
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;

    // Shift/rotate function select driven on ALUOp during T4
    localparam logic [2:0] ALU_SHR  = 3'd0;
    localparam logic [2:0] ALU_SHRA = 3'd1;
    localparam logic [2:0] ALU_SHL  = 3'd2;
    localparam logic [2:0] ALU_ROR  = 3'd3;
    localparam logic [2:0] ALU_ROL  = 3'd4;

    // IR field positions
    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    function automatic logic op_supported(input logic [4:0] op);
        logic ok;
        case (op)
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] op_to_alu(input logic [4:0] op);
        logic [2:0] f;
        case (op)
            OP_SHRA: f = ALU_SHRA;
            OP_SHL:  f = ALU_SHL;
            OP_ROR:  f = ALU_ROR;
            OP_ROL:  f = ALU_ROL;
            default: f = ALU_SHR;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// rtl/reg_sel_dec.sv - 4-bit register index to one-hot register select
//
// Purpose: drives exactly one select line for an in-range index when enabled,
// and no line at all when disabled or when the index is outside the register
// file, so the select bus can never carry more than one bit.
// Ports:
//   idx_i  in  4         register index
//   en_i   in  1         select enable
//   sel_o  out NUM_REGS  one-hot select (all zero when disabled/out of range)
module reg_sel_dec #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          idx_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en_i && (idx_i == 4'(i))) begin
                sel_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - control sequencer for shift/rotate instructions
//
// Purpose: steps a single-bus datapath through fetch (T0..T2) and execute
// (T3..T5) of SHR/SHRA/SHL/ROR/ROL instructions, stalling in T1 until memory
// data is ready. All outputs are decoded from the state register and the IR
// fields; IR is held stable by the datapath from T3 to T5.
// Ports:
//   Clock, Reset (sync, active-high), Start (sampled in IDLE only)
//   IR [DATA_W]          instruction register contents
//   MemReady             memory read data valid
//   PCout..Read          single-bit datapath strobes
//   Rout, Rin [NUM_REGS] one-hot register drive / load selects
//   ALUOp [3]            shift/rotate function select
//   Busy, Done, IllegalOp status
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_W     = 32,
    parameter int AUTO_FETCH = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [DATA_W-1:0]   IR,
    input  logic                MemReady,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [2:0]          ALUOp,
    output logic                Busy,
    output logic                Done,
    output logic                IllegalOp
);

    state_e state_q, state_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       instr_legal;
    logic       unused_ir_bits;

    logic       rout_en, rin_en;
    logic [3:0] rout_idx;

    assign opcode = IR[IR_OP_MSB:IR_OP_LSB];
    assign ra     = IR[IR_RA_MSB:IR_RA_LSB];
    assign rb     = IR[IR_RB_MSB:IR_RB_LSB];
    assign rc     = IR[IR_RC_MSB:IR_RC_LSB];

    // Low IR bits carry no meaning for shift instructions.
    assign unused_ir_bits = ^IR;

    function automatic logic reg_in_range(input logic [3:0] r);
        return ({1'b0, r} < 5'(NUM_REGS));
    endfunction

    // A register index beyond the register file makes the whole instruction
    // illegal, including Rc even though it only supplies the shift count.
    assign instr_legal = op_supported(opcode) && reg_in_range(ra)
                      && reg_in_range(rb) && reg_in_range(rc);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (MemReady) state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = instr_legal ? ST_T4 : ST_IDLE;
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = (AUTO_FETCH != 0) ? ST_T0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        ALUOp     = 3'd0;
        Done      = 1'b0;
        IllegalOp = 1'b0;
        rout_en   = 1'b0;
        rout_idx  = rb;
        rin_en    = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                // Held for the whole memory stall.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (instr_legal) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end else begin
                    IllegalOp = 1'b1;
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                ALUOp    = op_to_alu(opcode);
                Zin      = 1'b1;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                rin_en  = 1'b1;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy = (state_q != ST_IDLE);

    reg_sel_dec #(
        .NUM_REGS (NUM_REGS)
    ) u_rout_dec (
        .idx_i (rout_idx),
        .en_i  (rout_en),
        .sel_o (Rout)
    );

    reg_sel_dec #(
        .NUM_REGS (NUM_REGS)
    ) u_rin_dec (
        .idx_i (ra),
        .en_i  (rin_en),
        .sel_o (Rin)
    );

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Observed/expected per-cycle output picture. Strobe order:
    // PCout Zlowout MDRout MARin Zin PCin MDRin IRin Yin IncPC Read
    typedef struct packed {
        logic [10:0] strb;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [2:0]  alu;
        logic        busy;
        logic        done;
        logic        ill;
    } obs_t;

    localparam int S_PCOUT = 10, S_ZLOW = 9, S_MDROUT = 8, S_MARIN = 7, S_ZIN = 6;
    localparam int S_PCIN = 5, S_MDRIN = 4, S_IRIN = 3, S_YIN = 2, S_INCPC = 1, S_READ = 0;

    // DUT 0: defaults (16 registers, no auto-fetch)
    logic        rst0, start0, mr0;
    logic [31:0] ir0;
    logic        pco0, zlo0, mdro0, mari0, zin0, pci0, mdri0, iri0, yin0, inc0, rd0;
    logic [15:0] rout0, rin0;
    logic [2:0]  alu0;
    logic        busy0, done0, ill0;

    // DUT 1: 4 registers, auto-fetch
    logic        rst1, start1, mr1;
    logic [31:0] ir1;
    logic        pco1, zlo1, mdro1, mari1, zin1, pci1, mdri1, iri1, yin1, inc1, rd1;
    logic [3:0]  rout1, rin1;
    logic [2:0]  alu1;
    logic        busy1, done1, ill1;

    shift_sequencer dut0 (
        .Clock(clk), .Reset(rst0), .Start(start0), .IR(ir0), .MemReady(mr0),
        .PCout(pco0), .Zlowout(zlo0), .MDRout(mdro0), .MARin(mari0), .Zin(zin0),
        .PCin(pci0), .MDRin(mdri0), .IRin(iri0), .Yin(yin0), .IncPC(inc0), .Read(rd0),
        .Rout(rout0), .Rin(rin0), .ALUOp(alu0), .Busy(busy0), .Done(done0), .IllegalOp(ill0)
    );

    shift_sequencer #(.NUM_REGS(4), .DATA_W(32), .AUTO_FETCH(1)) dut1 (
        .Clock(clk), .Reset(rst1), .Start(start1), .IR(ir1), .MemReady(mr1),
        .PCout(pco1), .Zlowout(zlo1), .MDRout(mdro1), .MARin(mari1), .Zin(zin1),
        .PCin(pci1), .MDRin(mdri1), .IRin(iri1), .Yin(yin1), .IncPC(inc1), .Read(rd1),
        .Rout(rout1), .Rin(rin1), .ALUOp(alu1), .Busy(busy1), .Done(done1), .IllegalOp(ill1)
    );

    obs_t obs0, obs1;
    assign obs0 = {pco0, zlo0, mdro0, mari0, zin0, pci0, mdri0, iri0, yin0, inc0, rd0,
                   rout0, rin0, alu0, busy0, done0, ill0};
    assign obs1 = {pco1, zlo1, mdro1, mari1, zin1, pci1, mdri1, iri1, yin1, inc1, rd1,
                   12'b0, rout1, 12'b0, rin1, alu1, busy1, done1, ill1};

    obs_t q0[$];
    obs_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk_ir(input logic [4:0] op, input int ra, input int rb,
                                          input int rc, input logic [14:0] low);
        return {op, 4'(ra), 4'(rb), 4'(rc), low};
    endfunction

    function automatic bit ref_legal(input logic [31:0] ir, input int nregs,
                                     output logic [2:0] alu);
        logic [4:0] op;
        bit         ok;
        op = ir[31:27];
        ok = 1'b1;
        case (op)
            5'b00110: alu = 3'd0;
            5'b00111: alu = 3'd1;
            5'b01000: alu = 3'd2;
            5'b01001: alu = 3'd3;
            5'b01010: alu = 3'd4;
            default: begin alu = 3'd0; ok = 1'b0; end
        endcase
        if (int'(ir[26:23]) >= nregs || int'(ir[22:19]) >= nregs || int'(ir[18:15]) >= nregs)
            ok = 1'b0;
        return ok;
    endfunction

    // Phase: 0 idle, 1..6 = T0..T5
    function automatic obs_t ref_cycle(input int ph, input logic [31:0] ir, input int nregs);
        obs_t       e;
        logic [2:0] alu;
        bit         ok;
        e  = '0;
        ok = ref_legal(ir, nregs, alu);
        e.busy = (ph != 0);
        case (ph)
            1: begin
                e.strb[S_PCOUT] = 1'b1; e.strb[S_MARIN] = 1'b1;
                e.strb[S_INCPC] = 1'b1; e.strb[S_ZIN]   = 1'b1;
            end
            2: begin
                e.strb[S_ZLOW] = 1'b1; e.strb[S_PCIN]  = 1'b1;
                e.strb[S_READ] = 1'b1; e.strb[S_MDRIN] = 1'b1;
            end
            3: begin
                e.strb[S_MDROUT] = 1'b1; e.strb[S_IRIN] = 1'b1;
            end
            4: begin
                if (ok) begin
                    e.rout = 16'(1) << ir[22:19];
                    e.strb[S_YIN] = 1'b1;
                end else begin
                    e.ill = 1'b1;
                end
            end
            5: begin
                e.rout = 16'(1) << ir[18:15];
                e.alu  = alu;
                e.strb[S_ZIN] = 1'b1;
            end
            6: begin
                e.strb[S_ZLOW] = 1'b1;
                e.rin  = 16'(1) << ir[26:23];
                e.done = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // ---------------- stimulus ----------------
    // n_instr > 1 only on the auto-fetch DUT; rst_cyc counts cycles from T0 entry
    // (0 = no reset). Start is randomized on every busy cycle to show it is ignored.
    task automatic run(input int d, input logic [31:0] ir, input int k,
                       input int rst_cyc, input int n_instr);
        int         ph[$];
        bit         mr[$];
        int         nregs;
        logic [2:0] alu;
        bit         ok;
        nregs = (d == 0) ? 16 : 4;
        ok = ref_legal(ir, nregs, alu);
        for (int i = 0; i < n_instr; i++) begin
            ph.push_back(1); mr.push_back(1'($urandom_range(0, 1)));
            for (int j = 0; j <= k; j++) begin
                ph.push_back(2); mr.push_back(j == k);
            end
            ph.push_back(3); mr.push_back(1'($urandom_range(0, 1)));
            ph.push_back(4); mr.push_back(1'($urandom_range(0, 1)));
            if (!ok) break;
            ph.push_back(5); mr.push_back(1'($urandom_range(0, 1)));
            ph.push_back(6); mr.push_back(1'($urandom_range(0, 1)));
        end
        if (rst_cyc > 0) begin
            while (ph.size() > rst_cyc + 1) begin
                void'(ph.pop_back());
                void'(mr.pop_back());
            end
        end

        @(posedge clk); #1;
        if (d == 0) begin
            ir0 = ir; start0 = 1'b1; rst0 = 1'b0;
            q0.push_back(ref_cycle(0, ir, nregs));
            foreach (ph[c]) q0.push_back(ref_cycle(ph[c], ir, nregs));
        end else begin
            ir1 = ir; start1 = 1'b1; rst1 = 1'b0;
            q1.push_back(ref_cycle(0, ir, nregs));
            foreach (ph[c]) q1.push_back(ref_cycle(ph[c], ir, nregs));
        end
        foreach (ph[c]) begin
            @(posedge clk); #1;
            if (d == 0) begin
                start0 = 1'($urandom_range(0, 1));
                mr0    = mr[c];
                rst0   = (rst_cyc > 0) && (c == rst_cyc);
            end else begin
                start1 = 1'($urandom_range(0, 1));
                mr1    = mr[c];
                rst1   = (rst_cyc > 0) && (c == rst_cyc);
            end
        end
        @(posedge clk); #1;
        start0 = 1'b0; rst0 = 1'b0; mr0 = 1'($urandom_range(0, 1));
        start1 = 1'b0; rst1 = 1'b0; mr1 = 1'($urandom_range(0, 1));
    endtask

    // ---------------- monitor / scoreboard ----------------
    obs_t e0, e1;
    always @(negedge clk) begin
        e0 = (q0.size() > 0) ? q0.pop_front() : '0;
        checks++;
        if (obs0 !== e0) begin
            errors++;
            $display("FAIL dut0_cycle t=%0t: got %h expected %h", $time, obs0, e0);
        end
        e1 = (q1.size() > 0) ? q1.pop_front() : '0;
        checks++;
        if (obs1 !== e1) begin
            errors++;
            $display("FAIL dut1_cycle t=%0t: got %h expected %h", $time, obs1, e1);
        end
    end

    localparam logic [4:0] OPS [5] = '{5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010};

    initial begin
        rst0 = 1'b1; start0 = 1'b0; mr0 = 1'b0; ir0 = '0;
        rst1 = 1'b1; start1 = 1'b0; mr1 = 1'b0; ir1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(posedge clk);

        run(0, 32'h30918000, 0, 0, 1);      // SHR R1,R2,R3
        run(0, 32'h30918000, 3, 0, 1);      // same with 3 stall cycles in T1
        run(0, 32'h52988000, 0, 0, 1);      // ROL R5,R3,R1
        run(0, 32'h28918000, 1, 0, 1);      // unsupported opcode
        run(0, 32'h30918000, 0, 4, 1);      // reset during T4
        run(0, 32'h30918000, 2, 2, 1);      // reset during a T1 stall
        run(1, mk_ir(5'b00110, 5, 2, 3, 15'h0), 0, 0, 1);  // Ra out of range for 4 regs
        run(1, mk_ir(5'b00110, 1, 2, 3, 15'h0), 0, 11, 2); // back-to-back auto-fetch
        run(1, mk_ir(5'b01010, 3, 0, 1, 15'h0), 1, 13, 2); // auto-fetch with stalls

        for (int n = 0; n < 40; n++) begin
            int          d, k, sel, nregs, rmax, rc_, ninst, rst;
            logic [4:0]  op;
            logic [31:0] ir;
            logic [2:0]  alu;
            bit          ok;
            d     = $urandom_range(0, 1);
            nregs = (d == 0) ? 16 : 4;
            rmax  = (d == 0) ? 15 : 5;
            sel   = $urandom_range(0, 6);
            op    = (sel < 5) ? OPS[sel] : 5'($urandom_range(0, 31));
            rc_   = $urandom_range(0, rmax);
            ir    = mk_ir(op, $urandom_range(0, rmax), $urandom_range(0, rmax), rc_,
                          15'($urandom));
            k     = $urandom_range(0, 3);
            ok    = ref_legal(ir, nregs, alu);
            ninst = 1;
            rst   = 0;
            if (d == 1 && ok) begin
                ninst = $urandom_range(1, 3);
                rst   = ninst * (6 + k) - 1;
            end else if (d == 0 && $urandom_range(0, 3) == 0) begin
                rst = $urandom_range(1, (ok ? 5 : 3) + k);
            end
            run(d, ir, k, rst, ninst);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                     q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 16, number of general registers (2..16).
REQ-002 SHALL provide parameter DATA_W, default 32, width of IR.
REQ-003 SHALL provide parameter AUTO_FETCH, default 0; 1 = fetch next instruction after T5 without Start.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Clock  in  1  system clock, all state updates on rising edge.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 Start  in  1  request one instruction cycle; sampled only in IDLE.
REQ-008 IR  in  DATA_W  instruction register contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
REQ-009 MemReady  in  1  memory read data valid.
REQ-010 PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes.
REQ-011 Rout, Rin  out  NUM_REGS each  one-hot register bus-drive / load selects.
REQ-012 ALUOp  out  3  shift/rotate function select.
REQ-013 Busy  out  1  high in every state except IDLE.
REQ-014 Done  out  1  one-cycle pulse during T5.
REQ-015 IllegalOp  out  1  one-cycle pulse during T3 on an unsupported instruction.

Function
REQ-016 States SHALL be IDLE, T0, T1, T2, T3, T4, T5; all outputs SHALL be Moore decodes of the state register plus IR fields.
REQ-017 IDLE->T0 when Start=1; otherwise remain in IDLE.
REQ-018 T0: PCout, MARin, IncPC, Zin = 1; T0->T1 unconditionally.
REQ-019 T1: Zlowout, PCin, Read, MDRin = 1; remain in T1, all four held, until MemReady=1; T1->T2 on the edge sampling MemReady=1.
REQ-020 T2: MDRout, IRin = 1; T2->T3.
REQ-021 T3: decode IR; if legal, Rout=onehot(Rb), Yin=1, T3->T4; if illegal, IllegalOp=1, no other strobe, T3->IDLE.
REQ-022 Legal opcodes: SHR 00110 (ALUOp 0), SHRA 00111 (1), SHL 01000 (2), ROR 01001 (3), ROL 01010 (4); any other opcode, or any of Ra/Rb/Rc >= NUM_REGS, SHALL be illegal.
REQ-023 T4: Rout=onehot(Rc) (shift count), ALUOp per opcode, Zin=1; T4->T5.
REQ-024 T5: Zlowout=1, Rin=onehot(Ra), Done=1; T5->T0 if AUTO_FETCH=1, else T5->IDLE.
REQ-025 Rout and Rin SHALL never have more than one bit set; all strobes not listed for a state SHALL be 0.
REQ-026 Minimum instruction latency SHALL be 6 cycles (T0..T5); each MemReady=0 cycle in T1 adds one.
REQ-027 Start asserted while Busy=1 SHALL be ignored and not queued.
REQ-028 IR SHALL be treated as stable from T3 through T5; no IR copy is held internally.

Reset
REQ-029 Reset=1 SHALL force IDLE at the next rising edge from any state, including T1 stalls, overriding Start and MemReady.
REQ-030 In IDLE every output SHALL be 0 (all strobes, Rout, Rin, ALUOp, Busy, Done, IllegalOp).

Structure
REQ-031 Package shift_seq_pkg SHALL hold the state typedef, opcode constants, ALUOp constants and IR field bit positions.
REQ-032 One sub-module reg_sel_dec SHALL convert a 4-bit index plus enable into a NUM_REGS one-hot select; instantiated twice (Rout, Rin).

Verification
REQ-033 Start pulse, MemReady=1, IR=32'h30918000 (SHR R1,R2,R3) -> T0..T5 in 6 cycles; T3 Rout=16'h0004,Yin=1; T4 Rout=16'h0008,ALUOp=0,Zin=1; T5 Rin=16'h0002,Zlowout=1,Done=1; then IDLE.
REQ-034 Same as REQ-033 with MemReady=0 for first 3 T1 cycles -> T1 held 4 cycles with Read=MDRin=PCin=Zlowout=1; Done 9 cycles after T0 entry.
REQ-035 IR=32'h52988000 (ROL R5,R3,R1) -> T3 Rout=16'h0008; T4 Rout=16'h0002, ALUOp=4; T5 Rin=16'h0020.
REQ-036 IR=32'h28918000 (non-shift opcode) -> IllegalOp=1 for one cycle in T3, Yin/Rin/Done never asserted, IDLE next cycle; with NUM_REGS=4 and SHR Ra=5 likewise illegal.
REQ-037 Reset=1 during T4 -> next cycle IDLE, all outputs 0; Start pulses during T1..T5 produce no extra instruction cycle.
REQ-038 AUTO_FETCH=1, one Start -> T5 followed directly by T0, Busy continuously 1 across back-to-back instructions.
